register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register index width (2**ADDRESS_WIDTH registers).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-003 SHALL have parameter READ_PORTS, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter WRITE_PORTS, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL have parameter TRIGGER_REG, default 31, register loaded with 1 by trigger_i.
REQ-007 SHALL have parameter PROBE_REG, default 10, register driven on a0_o.
REQ-008 clk  input  1  single clock, all state updates on rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 rd_addr_i  input  READ_PORTS*ADDRESS_WIDTH  read addresses, port p at slice p.
REQ-011 rd_data_o  output  READ_PORTS*DATA_WIDTH  read data, port p at slice p.
REQ-012 rd_busy_o  output  READ_PORTS  scoreboard pending bit of rd_addr_i slice p.
REQ-013 wr_en_i  input  WRITE_PORTS  per-port write enable.
REQ-014 wr_addr_i  input  WRITE_PORTS*ADDRESS_WIDTH  write addresses.
REQ-015 wr_data_i  input  WRITE_PORTS*DATA_WIDTH  write data.
REQ-016 trigger_i  input  1  loads 1 into TRIGGER_REG.
REQ-017 busy_set_i  input  1  reserve busy_addr_i as pending write (issue stage).
REQ-018 busy_addr_i  input  ADDRESS_WIDTH  register to reserve.
REQ-019 a0_o  output  DATA_WIDTH  stored value of PROBE_REG.

Function
REQ-020 Register 0 SHALL read 0 on every port, ignore all writes/trigger, never be busy.
REQ-021 Writes SHALL commit at rising clk when wr_en_i[w]=1 and wr_addr_i[w]!=0.
REQ-022 Same-address writes in one cycle: highest-index port SHALL win.
REQ-023 trigger_i=1 SHALL write 1 to TRIGGER_REG with priority over all write ports.
REQ-024 Reads SHALL be combinational from stored array, zero-cycle latency.
REQ-025 BYPASS=1: read of an address committed this cycle SHALL return the winning write value (trigger's 1 included); BYPASS=0: old stored value.
REQ-026 a0_o SHALL show stored PROBE_REG only, never bypassed (one-cycle lag after write).
REQ-027 Scoreboard: one busy bit per register; busy_set_i=1 with busy_addr_i!=0 SHALL set bit at next edge.
REQ-028 Committed write (any port or trigger) to register r SHALL clear busy[r] at same edge.
REQ-029 Set and clear of same register in one cycle: set SHALL win (new in-flight producer).
REQ-030 rd_busy_o[p] SHALL be registered busy bit, not bypassed; address 0 -> 0.
REQ-031 Address widths SHALL be exact; no out-of-range index possible.

Reset
REQ-032 rst=1 at rising edge SHALL clear all registers and busy bits to 0, overriding writes, trigger, busy_set_i.
REQ-033 After reset: rd_data_o=0, rd_busy_o=0, a0_o=0 until first post-reset write.
REQ-034 rst asserted mid-operation SHALL discard same-cycle writes; no partial state retained.

Verification
REQ-035 Reset then read all 32 addresses on both ports -> all 0, rd_busy_o=0, a0_o=0.
REQ-036 Port0 write x5=0xDEADBEEF, port1 write x5=0x12345678 same cycle, BYPASS=1 read x5 -> 0x12345678 same cycle and after.
REQ-037 Write x0=0xFFFFFFFF with busy_set_i on x0 -> read x0=0, rd_busy_o=0.
REQ-038 trigger_i=1 with port1 writing x31=0xAA -> x31=1; busy[31] cleared.
REQ-039 busy_set_i x10; next cycle rd_busy_o=1 for x10; write x10=7 with busy_set_i x10 -> stays busy, a0_o=7 next cycle; write alone -> busy 0.
REQ-040 Write x3=9 with rst=1 same cycle -> x3 reads 0 after edge.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, write ports, trigger,
// scoreboard reservation and probe output.
interface register_file_mp_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 2
);
  logic [READ_PORTS*ADDRESS_WIDTH-1:0]  rd_addr_i;
  logic [READ_PORTS*DATA_WIDTH-1:0]     rd_data_o;
  logic [READ_PORTS-1:0]                rd_busy_o;
  logic [WRITE_PORTS-1:0]               wr_en_i;
  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] wr_addr_i;
  logic [WRITE_PORTS*DATA_WIDTH-1:0]    wr_data_i;
  logic                                 trigger_i;
  logic                                 busy_set_i;
  logic [ADDRESS_WIDTH-1:0]             busy_addr_i;
  logic [DATA_WIDTH-1:0]                a0_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, trigger_i, busy_set_i, busy_addr_i,
    input  rd_data_o, rd_busy_o, a0_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, trigger_i, busy_set_i, busy_addr_i,
    output rd_data_o, rd_busy_o, a0_o
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with hardwired-zero x0, trigger register,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module register_file_mp #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 2,
  parameter int BYPASS        = 1,
  parameter int TRIGGER_REG   = 31,
  parameter int PROBE_REG     = 10
) (
  input logic clk,
  input logic rst,
  register_file_mp_if.slave bus
);
  localparam int NREG = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;

  // Per-register commit decision for this edge; shared by state update and bypass.
  logic [NREG-1:0]       wr_hit;
  logic [DATA_WIDTH-1:0] wr_val [NREG];

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      if (!rst && r != 0) begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (bus.wr_en_i[w] &&
              bus.wr_addr_i[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ADDRESS_WIDTH'(r)) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = bus.wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (bus.trigger_i && r == TRIGGER_REG) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = DATA_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      busy_d[r] = busy_q[r];
      if (rst || r == 0) begin
        regs_d[r] = '0;
        busy_d[r] = 1'b0;
      end else begin
        if (wr_hit[r]) begin
          regs_d[r] = wr_val[r];
          busy_d[r] = 1'b0;
        end
        if (bus.busy_set_i && bus.busy_addr_i == ADDRESS_WIDTH'(r))
          busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
    busy_q <= busy_d;
  end

  always_comb begin
    logic [ADDRESS_WIDTH-1:0] a;
    a              = '0;
    bus.rd_data_o  = '0;
    bus.rd_busy_o  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      a = bus.rd_addr_i[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (BYPASS != 0 && wr_hit[a])
        bus.rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wr_val[a];
      else
        bus.rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[a];
      bus.rd_busy_o[p] = busy_q[a];
    end
  end

  assign bus.a0_o = regs_q[ADDRESS_WIDTH'(PROBE_REG)];

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized and directed bench for register_file_mp against an
// array-based reference model of the register file and scoreboard.
module tb_register_file_mp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RP = 2;
  localparam int WP = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  register_file_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                        .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

  register_file_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP),
                     .WRITE_PORTS(WP), .BYPASS(1), .TRIGGER_REG(31),
                     .PROBE_REG(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what each register holds and whether it is reserved.
  logic [DW-1:0] m_regs [32];
  bit            m_busy [32];
  bit            p_hit  [32];
  logic [DW-1:0] p_val  [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.wr_en_i     = '0;
    bus.wr_addr_i   = '0;
    bus.wr_data_i   = '0;
    bus.trigger_i   = 1'b0;
    bus.busy_set_i  = 1'b0;
    bus.busy_addr_i = '0;
    rst             = 1'b0;
  endtask

  task automatic wr(input int port, input int addr, input logic [DW-1:0] data);
    bus.wr_en_i[port]             = 1'b1;
    bus.wr_addr_i[port*AW +: AW]  = AW'(addr);
    bus.wr_data_i[port*DW +: DW]  = data;
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rd_addr_i[0 +: AW]  = AW'(a0);
    bus.rd_addr_i[AW +: AW] = AW'(a1);
  endtask

  // What the coming edge will commit: ports in order (later port wins), then trigger on x31.
  task automatic compute_pending();
    int a;
    for (int r = 0; r < 32; r++) begin
      p_hit[r] = 0;
      p_val[r] = '0;
    end
    if (!rst) begin
      for (int w = 0; w < WP; w++) begin
        a = int'(bus.wr_addr_i[w*AW +: AW]);
        if (bus.wr_en_i[w] && a != 0) begin
          p_hit[a] = 1;
          p_val[a] = bus.wr_data_i[w*DW +: DW];
        end
      end
      if (bus.trigger_i) begin
        p_hit[31] = 1;
        p_val[31] = 1;
      end
    end
  endtask

  // Inputs are already applied; check outputs mid-cycle, then advance one edge.
  task automatic cycle();
    int a;
    logic [DW-1:0] exp_d;
    #2;
    compute_pending();
    for (int p = 0; p < RP; p++) begin
      a = int'(bus.rd_addr_i[p*AW +: AW]);
      exp_d = p_hit[a] ? p_val[a] : m_regs[a];
      if (a == 0) exp_d = '0;
      chk($sformatf("rd_data%0d x%0d", p, a), 64'(bus.rd_data_o[p*DW +: DW]), 64'(exp_d));
      chk($sformatf("rd_busy%0d x%0d", p, a), 64'(bus.rd_busy_o[p]),
          64'((a == 0) ? 1'b0 : m_busy[a]));
    end
    chk("a0", 64'(bus.a0_o), 64'(m_regs[10]));
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) begin
      if (rst) begin
        m_regs[r] = '0;
        m_busy[r] = 0;
      end else if (p_hit[r]) begin
        m_regs[r] = p_val[r];
        m_busy[r] = 0;
      end
    end
    if (!rst && bus.busy_set_i && bus.busy_addr_i != 0) m_busy[int'(bus.busy_addr_i)] = 1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 'x;
      m_busy[r] = 0;
    end
    bus.rd_addr_i = '0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    idle();

    // all addresses read zero and idle after reset
    for (int r = 0; r < 32; r++) begin
      rd(r, 31 - r);
      cycle();
    end

    // same-cycle double write to x5, higher port wins, bypassed
    rd(5, 5);
    wr(0, 5, 32'hDEADBEEF);
    wr(1, 5, 32'h12345678);
    cycle();
    idle();
    cycle();
    chk("x5 after dual write", 64'(bus.rd_data_o[DW +: DW]), 64'h12345678);

    // x0 is immune to writes and reservations
    rd(0, 0);
    wr(0, 0, 32'hFFFFFFFF);
    bus.busy_set_i = 1'b1;
    bus.busy_addr_i = '0;
    cycle();
    idle();
    cycle();
    chk("x0 busy", 64'(bus.rd_busy_o[0]), 64'h0);

    // trigger beats port 1 and clears the reservation on x31
    rd(31, 31);
    bus.busy_set_i = 1'b1;
    bus.busy_addr_i = 5'd31;
    cycle();
    idle();
    bus.trigger_i = 1'b1;
    wr(1, 31, 32'hAA);
    cycle();
    idle();
    cycle();
    chk("x31 trigger", 64'(bus.rd_data_o[0 +: DW]), 64'h1);
    chk("x31 busy cleared", 64'(bus.rd_busy_o[0]), 64'h0);

    // reservation persists through a same-cycle write, then clears
    rd(10, 10);
    bus.busy_set_i = 1'b1;
    bus.busy_addr_i = 5'd10;
    cycle();
    idle();
    wr(0, 10, 32'd7);
    bus.busy_set_i = 1'b1;
    bus.busy_addr_i = 5'd10;
    cycle();
    idle();
    chk("x10 still busy", 64'(bus.rd_busy_o[0]), 64'h1);
    chk("a0 lag", 64'(bus.a0_o), 64'd7);
    wr(1, 10, 32'd8);
    cycle();
    idle();
    cycle();
    chk("x10 busy released", 64'(bus.rd_busy_o[1]), 64'h0);

    // reset discards a same-cycle write
    rd(3, 3);
    wr(0, 3, 32'd9);
    rst = 1'b1;
    cycle();
    idle();
    cycle();
    chk("x3 after rst", 64'(bus.rd_data_o[0 +: DW]), 64'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int w = 0; w < WP; w++)
        if ($urandom_range(0, 2) != 0)
          wr(w, int'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) wr(1, int'(bus.wr_addr_i[0 +: AW]), $urandom);
      bus.trigger_i   = ($urandom_range(0, 9) == 0);
      bus.busy_set_i  = ($urandom_range(0, 1) == 0);
      bus.busy_addr_i = AW'($urandom_range(0, 31));
      rst             = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) rd(int'(bus.wr_addr_i[AW +: AW]), int'(bus.busy_addr_i));
      else rd(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
